// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampled UART receiver returning one parallel word per frame
//
// Frame on the line: start bit (0), Width data bits LSB first, optional parity
// bit, one stop bit (1). Clk runs at Prescale x bit rate; each bit occupies
// edges 0..Prescale-1 of edge_cnt and is sampled around mid-bit.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - 2-of-3 vote over edges Prescale/2-1, Prescale/2, Prescale/2+1
//   undefined - single sample at edge Prescale/2
//
// Ports:
//   Clk          oversampling clock, rising edge
//   Rst          synchronous active-low reset
//   RX_In        serial line, idle high, already synchronised to Clk
//   Prescale     Clk cycles per bit (8, 16 or 32), latched at the start edge
//   Parity_En    parity bit present, latched at the start edge
//   Parity_Typ   0 = even, 1 = odd, latched at the start edge
//   P_Data       last good word, held until the next good frame
//   Data_Valid   one-cycle pulse, P_Data updated this cycle
//   Parity_Error one-cycle pulse, parity mismatch
//   Stop_Error   one-cycle pulse, stop bit sampled 0

module uart_rx_frame #(
  parameter int Width      = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  RX_In,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Parity_En,
  input  logic                  Parity_Typ,
  output logic [Width-1:0]      P_Data,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int BW = (Width > 1) ? $clog2(Width) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [BW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err;
  logic                  sample;
  logic [Width-1:0]      shreg;

  logic                  frame_start;
  logic                  bit_end;
  logic                  last_data_bit;
  logic                  sample_now;
  logic                  sample_val;

  assign frame_start   = (state == IDLE) && !RX_In;
  assign bit_end       = (state != IDLE) && (edge_cnt == prescale_q - PRESCALE_W'(1));
  assign last_data_bit = (bit_cnt == BW'(Width - 1));

`ifdef UART_RX_MAJORITY_EN
  // rx_hist[0] holds the line at edge Prescale/2, rx_hist[1] at Prescale/2-1
  // when edge_cnt reaches Prescale/2+1; the vote is registered one edge later.
  logic [1:0] rx_hist;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], RX_In};
    end
  end

  assign sample_now = (state != IDLE) && (edge_cnt == (prescale_q >> 1) + PRESCALE_W'(1));
  assign sample_val = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & RX_In) | (rx_hist[0] & RX_In);
`else
  assign sample_now = (state != IDLE) && (edge_cnt == (prescale_q >> 1));
  assign sample_val = RX_In;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_In) next_state = START;
      // A start bit that reads high at mid-bit was a glitch, not a frame.
      START:   if (bit_end) next_state = sample ? IDLE : DATA;
      DATA:    if (bit_end && last_data_bit) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      edge_cnt     <= '0;
      prescale_q   <= '0;
      bit_cnt      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_err      <= 1'b0;
      sample       <= 1'b1;
      shreg        <= '0;
      P_Data       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;

      // The start-edge cycle is edge 0, so counting resumes at 1.
      if (frame_start) begin
        prescale_q <= Prescale;
        par_en_q   <= Parity_En;
        par_typ_q  <= Parity_Typ;
        par_err    <= 1'b0;
        bit_cnt    <= '0;
        edge_cnt   <= PRESCALE_W'(1);
      end else if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
      end

      if (sample_now) begin
        sample <= sample_val;
      end

      if (bit_end) begin
        case (state)
          DATA: begin
            // LSB arrives first, so after Width shifts it sits in bit 0.
            shreg   <= {sample, shreg[Width-1:1]};
            bit_cnt <= last_data_bit ? '0 : bit_cnt + BW'(1);
          end
          PARITY: begin
            par_err <= (sample != (par_typ_q ? ~^shreg : ^shreg));
          end
          STOP: begin
            Stop_Error   <= ~sample;
            Parity_Error <= par_err;
            if (sample && !par_err) begin
              Data_Valid <= 1'b1;
              P_Data     <= shreg;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized and directed frame check of uart_rx_frame against a frame-level model

module tb_uart_rx_frame;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       RX_In = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       Parity_En = 1'b0;
  logic       Parity_Typ = 1'b0;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  uart_rx_frame #(.Width(8), .PRESCALE_W(6)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .RX_In        (RX_In),
    .Prescale     (Prescale),
    .Parity_En    (Parity_En),
    .Parity_Typ   (Parity_Typ),
    .P_Data       (P_Data),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  typedef struct {
    int         cyc;
    bit         rst;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  ev_t        cur_ev;
  logic [7:0] exp_pdata = 8'h00;
  bit         e_dv, e_pe, e_se;
  bit         chk_en = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         n_dv = 0, n_pe = 0, n_se = 0;
  int         last_dv = -1, prev_dv = -1, last_pe = -1, last_se = -1;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level expectation queue.
  always @(negedge Clk) begin
    if (chk_en) begin
      e_dv = 1'b0;
      e_pe = 1'b0;
      e_se = 1'b0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        cur_ev = evq.pop_front();
        if (cur_ev.rst) exp_pdata = 8'h00;
        e_dv = cur_ev.dv;
        e_pe = cur_ev.pe;
        e_se = cur_ev.se;
        if (cur_ev.dv) exp_pdata = cur_ev.data;
      end
      check("data_valid", Data_Valid, e_dv);
      check("parity_error", Parity_Error, e_pe);
      check("stop_error", Stop_Error, e_se);
      check("p_data", P_Data, exp_pdata);
      if (Data_Valid === 1'b1) begin n_dv++; prev_dv = last_dv; last_dv = cyc; end
      if (Parity_Error === 1'b1) begin n_pe++; last_pe = cyc; end
      if (Stop_Error === 1'b1) begin n_se++; last_se = cyc; end
    end
  end

  task automatic drive(input logic v);
    @(posedge Clk);
    #1;
    RX_In = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask

  // Sends one frame; gbit >= 0 inverts the line for one cycle at mid-bit of that
  // data bit; abort_at >= 0 pulls Rst low at that cycle offset and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                            input bit bad_par, input bit bad_stop, input int gbit,
                            input int abort_at, output int t0);
    bit         bits[$];
    bit         pbit;
    bit         v;
    logic [7:0] rx;
    int         n;
    ev_t        ev;
    pbit = bit'(($countones(d) + int'(ptyp)) % 2) ^ bad_par;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(!bad_stop);
    n = bits.size();
    t0 = 0;
    for (int b = 0; b < n; b++) begin
      for (int e = 0; e < p; e++) begin
        @(posedge Clk);
        #1;
        if (b == 0 && e == 0) begin
          t0 = cyc;
          Prescale = 6'(p);
          Parity_En = pen;
          Parity_Typ = ptyp;
        end else if (b == 0 && e == 1) begin
          Prescale = 6'(8 << $urandom_range(0, 2));
          Parity_En = 1'($urandom);
          Parity_Typ = 1'($urandom);
        end
        if (abort_at >= 0 && b * p + e == abort_at) begin
          Rst = 1'b0;
          RX_In = 1'b1;
          ev = '{cyc: cyc + 1, rst: 1'b1, dv: 1'b0, pe: 1'b0, se: 1'b0, data: 8'h00};
          evq.push_back(ev);
          return;
        end
        v = bits[b];
        if (gbit >= 0 && b == gbit + 1 && e == p / 2) v = ~v;
        RX_In = v;
      end
    end
    rx = d;
    if (gbit >= 0 && !MAJ) rx[gbit] = ~rx[gbit];
    ev.cyc  = t0 + n * p;
    ev.rst  = 1'b0;
    ev.se   = bad_stop;
    ev.pe   = pen && ((($countones(rx) + int'(pbit)) % 2) != int'(ptyp));
    ev.dv   = !ev.se && !ev.pe;
    ev.data = rx;
    evq.push_back(ev);
  endtask

  task automatic send_glitch(input int low_len, input int p, output int t0);
    t0 = 0;
    for (int e = 0; e < p; e++) begin
      @(posedge Clk);
      #1;
      if (e == 0) begin
        t0 = cyc;
        Prescale = 6'(p);
      end
      RX_In = (e < low_len) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int t0, t1, k_dv, k_pe, k_se, p, gap;
    bit pen, ptyp, bp, bs;
    int g;

    repeat (4) @(posedge Clk);
    #1;
    Rst = 1'b1;
    chk_en = 1'b1;
    check("reset_p_data", P_Data, 8'h00);
    check("reset_flags", {Data_Valid, Parity_Error, Stop_Error}, 3'b000);
    idle(3);

    // 0xA5, Prescale 8, no parity
    send_frame(8'hA5, 8, 0, 0, 0, 0, -1, -1, t0);
    idle(2);
    check("a5_dv_time", last_dv - t0, 80);
    check("a5_pdata", P_Data, 8'hA5);
    check("a5_no_errors", n_pe + n_se, 0);

    // 0x3C, Prescale 16, even parity: good then bad parity bit
    send_frame(8'h3C, 16, 1, 0, 0, 0, -1, -1, t0);
    idle(2);
    check("3c_dv_time", last_dv - t0, 176);
    check("3c_pdata", P_Data, 8'h3C);
    k_dv = n_dv;
    send_frame(8'h3C, 16, 1, 0, 1, 0, -1, -1, t0);
    idle(2);
    check("3c_pe_time", last_pe - t0, 176);
    check("3c_bad_no_dv", n_dv - k_dv, 0);
    check("3c_bad_pdata_held", P_Data, 8'h3C);

    // 0x55 with stop bit 0, then 0x12
    k_dv = n_dv;
    send_frame(8'h55, 8, 0, 0, 0, 1, -1, -1, t0);
    idle(2);
    check("55_se_time", last_se - t0, 80);
    check("55_no_dv", n_dv - k_dv, 0);
    check("55_pdata_held", P_Data, 8'h3C);
    send_frame(8'h12, 8, 0, 0, 0, 0, -1, -1, t0);
    idle(2);
    check("12_pdata", P_Data, 8'h12);

    // start glitch (3 low cycles) immediately followed by a real frame
    k_dv = n_dv; k_pe = n_pe; k_se = n_se;
    send_glitch(3, 8, t0);
    send_frame(8'h81, 8, 0, 0, 0, 0, -1, -1, t1);
    idle(2);
    check("glitch_one_dv", n_dv - k_dv, 1);
    check("glitch_no_err", (n_pe - k_pe) + (n_se - k_se), 0);
    check("81_dv_time", last_dv - t0, 88);
    check("81_pdata", P_Data, 8'h81);

    // back-to-back, Prescale 32, odd parity
    k_dv = n_dv;
    send_frame(8'h01, 32, 1, 1, 0, 0, -1, -1, t0);
    send_frame(8'hFE, 32, 1, 1, 0, 0, -1, -1, t1);
    idle(2);
    check("b2b_two_dv", n_dv - k_dv, 2);
    check("b2b_spacing", last_dv - prev_dv, 352);
    check("b2b_first_time", prev_dv - t0, 352);
    check("fe_pdata", P_Data, 8'hFE);

    // reset at t0+40 of a Prescale 8 frame
    k_dv = n_dv; k_pe = n_pe; k_se = n_se;
    send_frame(8'h5A, 8, 0, 0, 0, 0, -1, 40, t0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    check("rst_cycle", cyc - t0, 41);
    check("rst_pdata", P_Data, 8'h00);
    check("rst_flags", {Data_Valid, Parity_Error, Stop_Error}, 3'b000);
    idle(100);
    check("rst_no_pulse", (n_dv - k_dv) + (n_pe - k_pe) + (n_se - k_se), 0);
    send_frame(8'hC3, 8, 0, 0, 0, 0, -1, -1, t0);
    idle(2);
    check("c3_pdata", P_Data, 8'hC3);
    check("c3_dv_time", last_dv - t0, 80);

    // one-cycle inversion at mid-bit of data bit 3, Prescale 16
    send_frame(8'hA5, 16, 0, 0, 0, 0, 3, -1, t0);
    idle(2);
    check("midbit_glitch_pdata", P_Data, MAJ ? 8'hA5 : 8'hAD);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      p    = 8 << $urandom_range(0, 2);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      bp   = pen && ($urandom_range(0, 4) == 0);
      bs   = ($urandom_range(0, 5) == 0);
      g    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      if ($urandom_range(0, 7) == 0) send_glitch($urandom_range(1, p / 2 - 1), p, t0);
      send_frame(8'($urandom), p, pen, ptyp, bp, bs, g, -1, t0);
      gap = $urandom_range(0, 3);
      idle(gap);
    end

    idle(20);
    check("queue_drained", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
